// File: rtl/can_destuff_gen_pkg.sv
// can_pkg: shared CAN / CAN FD constants, bit classes and a Gray encoder.
// No ports; imported by the destuffer, its interface and the counter.
package can_pkg;

  localparam logic RECESSIVE = 1'b1;

  localparam int CAN_RUN_LEN          = 5;
  localparam int CANFD_FIXED_INTERVAL = 4;
  localparam int CANFD_STUFF_CNT_W    = 3;

  localparam int GRAY_MAX_W = 16;

  typedef enum logic [1:0] {
    BIT_NONE,
    BIT_DATA,
    BIT_STUFF
  } bit_cls_e;

  function automatic logic [GRAY_MAX_W-1:0] gray_enc(
    input logic [GRAY_MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/can_destuff_gen_if.sv
// can_destuff_gen_if: sampled-bit input bundle and destuffed output bundle.
// master drives bit_valid/rxin/en/fixed_mode/restart; slave drives results.
interface can_destuff_gen_if
  import can_pkg::*;
#(
  parameter int CNT_W = CANFD_STUFF_CNT_W
);
  logic             bit_valid;
  logic             rxin;
  logic             en;
  logic             fixed_mode;
  logic             restart;
  logic             rxout;
  logic             out_valid;
  logic             stuff_dropped;
  logic [CNT_W-1:0] stuff_cnt;
  logic [CNT_W-1:0] stuff_cnt_gray;
  logic             stuff_cnt_par;
  logic             err;
  logic             err_pulse;

  modport master (
    output bit_valid, rxin, en, fixed_mode, restart,
    input  rxout, out_valid, stuff_dropped,
    input  stuff_cnt, stuff_cnt_gray, stuff_cnt_par,
    input  err, err_pulse
  );

  modport slave (
    input  bit_valid, rxin, en, fixed_mode, restart,
    output rxout, out_valid, stuff_dropped,
    output stuff_cnt, stuff_cnt_gray, stuff_cnt_par,
    output err, err_pulse
  );

endinterface

// File: rtl/can_destuff_gen_cnt_enc.sv
// can_stuff_cnt_enc: modulo stuff-bit counter with Gray and even parity.
// Ports: i_clk, i_rst_n, i_clr, i_inc -> o_cnt, o_gray, o_par.
module can_stuff_cnt_enc
  import can_pkg::*;
#(
  parameter int CNT_W = CANFD_STUFF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_gray,
  output logic             o_par
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_gray = CNT_W'(gray_enc(GRAY_MAX_W'(r_cnt)));
  assign o_par  = ^o_gray;

endmodule

// File: rtl/can_destuff_gen.sv
// can_destuff_gen: CAN dynamic / CAN FD fixed bit destuffer, one bit/clock.
// Ports: clkin, rstn (async low), bus (slave modport of can_destuff_gen_if).
module can_destuff_gen
  import can_pkg::*;
#(
  parameter int RUN_LEN        = CAN_RUN_LEN,
  parameter int FIXED_INTERVAL = CANFD_FIXED_INTERVAL,
  parameter int CNT_W          = CANFD_STUFF_CNT_W
) (
  input logic              clkin,
  input logic              rstn,
  can_destuff_gen_if.slave bus
);

  localparam int RW = $clog2(RUN_LEN + 1);
  localparam int FW = $clog2(FIXED_INTERVAL + 1);
  localparam logic [RW-1:0] RUN_C = RW'(RUN_LEN);
  localparam logic [FW-1:0] FIX_C = FW'(FIXED_INTERVAL);

  logic          r_last;
  logic [RW-1:0] r_run;
  logic [FW-1:0] r_fix;
  logic          r_fm;
  logic          r_err;
  logic          r_rxout;
  logic          r_ov;
  logic          r_drop;
  logic          r_errp;

  logic          w_last;
  logic [RW-1:0] w_run;
  logic [FW-1:0] w_fix;
  logic          w_fm;
  logic          w_err;
  logic          w_errp;
  logic          w_rxout;
  logic          w_clr;
  logic          w_inc;
  bit_cls_e      w_cls;

  logic w_same;
  logic w_pass;
  logic w_fxd;
  logic w_dyn;
  logic w_dstart;
  logic w_dstuff;
  logic w_ddata;

  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_gray;
  logic             w_par;

  // Mutually exclusive bit-handling cases; fm_q=1 in dynamic
  // mode means we just left fixed mode, so the bit restarts the run.
  assign w_same   = (bus.rxin == r_last);
  assign w_pass   = ~bus.en;
  assign w_fxd    = bus.en & bus.fixed_mode;
  assign w_dyn    = bus.en & ~bus.fixed_mode;
  assign w_dstart = w_dyn & ((r_run == '0) | r_fm);
  assign w_dstuff = w_dyn & ~w_dstart & (r_run == RUN_C);
  assign w_ddata  = w_dyn & ~w_dstart & ~w_dstuff;

  always_comb begin
    w_last = r_last;
    w_run  = r_run;
    w_fix  = r_fix;
    w_fm   = r_fm;
    w_err  = r_err;
    w_errp = 1'b0;
    w_clr  = 1'b0;
    w_inc  = 1'b0;
    w_cls  = BIT_NONE;
    if (bus.restart) begin
      w_last = 1'b0;
      w_run  = '0;
      w_fix  = '0;
      w_fm   = 1'b0;
      w_err  = 1'b0;
      w_clr  = 1'b1;
      if (bus.bit_valid) begin
        w_cls  = BIT_DATA;
        w_last = bus.rxin;
        w_run  = bus.en ? RW'(1) : '0;
      end
    end else if (bus.bit_valid) begin
      w_last = bus.rxin;
      unique case (1'b1)
        w_pass: begin
          w_cls = BIT_DATA;
          w_run = '0;
          w_fix = '0;
          w_fm  = 1'b0;
          w_err = 1'b0;
          w_clr = 1'b1;
        end
        w_fxd: begin
          w_fm = 1'b1;
          if (!r_fm || r_fix == FIX_C) begin
            w_cls  = BIT_STUFF;
            w_fix  = '0;
            w_errp = w_same;
          end else begin
            w_cls = BIT_DATA;
            w_fix = r_fix + FW'(1);
          end
        end
        w_dstart: begin
          w_cls = BIT_DATA;
          w_run = RW'(1);
          w_fm  = 1'b0;
        end
        w_dstuff: begin
          w_cls  = BIT_STUFF;
          w_inc  = 1'b1;
          w_run  = RW'(1);
          w_errp = w_same;
        end
        w_ddata: begin
          w_cls = BIT_DATA;
          w_run = w_same ? r_run + RW'(1) : RW'(1);
        end
        default: ;
      endcase
      if (w_errp) begin
        w_err = 1'b1;
      end
    end
    w_rxout = (w_cls == BIT_DATA) ? bus.rxin : r_rxout;
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      r_last  <= RECESSIVE;
      r_run   <= '0;
      r_fix   <= '0;
      r_fm    <= 1'b0;
      r_err   <= 1'b0;
      r_rxout <= RECESSIVE;
      r_ov    <= 1'b0;
      r_drop  <= 1'b0;
      r_errp  <= 1'b0;
    end else begin
      r_last  <= w_last;
      r_run   <= w_run;
      r_fix   <= w_fix;
      r_fm    <= w_fm;
      r_err   <= w_err;
      r_rxout <= w_rxout;
      r_ov    <= (w_cls == BIT_DATA);
      r_drop  <= (w_cls == BIT_STUFF);
      r_errp  <= w_errp;
    end
  end

  can_stuff_cnt_enc #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk   (clkin),
    .i_rst_n (rstn),
    .i_clr   (w_clr),
    .i_inc   (w_inc),
    .o_cnt   (w_cnt),
    .o_gray  (w_gray),
    .o_par   (w_par)
  );

  assign bus.rxout          = r_rxout;
  assign bus.out_valid      = r_ov;
  assign bus.stuff_dropped  = r_drop;
  assign bus.err            = r_err;
  assign bus.err_pulse      = r_errp;
  assign bus.stuff_cnt      = w_cnt;
  assign bus.stuff_cnt_gray = w_gray;
  assign bus.stuff_cnt_par  = w_par;

endmodule
